// File: rtl/mul2_seq_ctrl.sv
// Sequential W x W unsigned multiplier built from one reused 2x2 multiplier cell,
// with valid/ready handshakes on both the operand and product sides.

// 2-bit x 2-bit unsigned combinational multiplier cell.
module bin_mul_2_2 (
    input  logic x1,
    input  logic x0,
    input  logic y1,
    input  logic y0,
    output logic z3,
    output logic z2,
    output logic z1,
    output logic z0
);

    // Sum-of-products form of {x1,x0} * {y1,y0}
    assign z0 = x0 & y0;
    assign z1 = (x1 & y0) ^ (x0 & y1);
    assign z2 = (x1 & y1) ^ (x1 & x0 & y1 & y0);
    assign z3 = x1 & x0 & y1 & y0;

endmodule

module mul2_seq_ctrl #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  product,
    output logic            busy,
    output logic [CW-1:0]   op_count
);

    localparam int unsigned D  = W / 2;
    localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned PW = 2 * W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            step;
    logic            finish;
    logic            hshk;

    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [IW-1:0]   i_q;
    logic [IW-1:0]   j_q;
    logic [PW-1:0]   acc_q;

    logic            i_last;
    logic            j_last;
    logic [1:0]      x_dig;
    logic [1:0]      y_dig;
    logic [3:0]      z;
    logic [IW:0]     dig_sum;
    logic [IW+1:0]   shamt;
    logic [PW-1:0]   term;
    logic [PW-1:0]   acc_sum;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == RUN);

    assign i_last = (i_q == IW'(D - 1));
    assign j_last = (j_q == IW'(D - 1));

    // Select the current operand digits and weight the cell output by 4^(i+j)
    assign x_dig   = 2'(a_r >> {i_q, 1'b0});
    assign y_dig   = 2'(b_r >> {j_q, 1'b0});
    assign dig_sum = {1'b0, i_q} + {1'b0, j_q};
    assign shamt   = {dig_sum, 1'b0};
    assign term    = PW'(z) << shamt;
    assign acc_sum = acc_q + term;

    bin_mul_2_2 u_cell (
        .x1 (x_dig[1]),
        .x0 (x_dig[0]),
        .y1 (y_dig[1]),
        .y0 (y_dig[0]),
        .z3 (z[3]),
        .z2 (z[2]),
        .z1 (z[1]),
        .z0 (z[0])
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        hshk    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (i_last && j_last) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    hshk    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, digit walk, accumulation and result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                acc_q <= '0;
                i_q   <= '0;
                j_q   <= '0;
            end
            if (step) begin
                acc_q <= acc_sum;
                if (j_last) begin
                    j_q <= '0;
                    i_q <= i_q + IW'(1);
                end else begin
                    j_q <= j_q + IW'(1);
                end
            end
            if (finish) begin
                product   <= acc_sum;
                out_valid <= 1'b1;
            end
            if (hshk) begin
                out_valid <= 1'b0;
                op_count  <= op_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul2_seq_ctrl.sv
// Scoreboard bench for mul2_seq_ctrl at W=8 and at the W=2 corner.
module tb_mul2_seq_ctrl;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;
    logic [15:0] op_count;

    logic        in_valid2;
    logic        in_ready2;
    logic [1:0]  a2;
    logic [1:0]  b2;
    logic        out_valid2;
    logic        out_ready2;
    logic [3:0]  product2;
    logic        busy2;
    logic [15:0] op_count2;

    int          n_vec;
    int          n_miss;
    logic [15:0] exp_q[$];
    logic [3:0]  exp2_q[$];

    mul2_seq_ctrl #(.W(8), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .op_count  (op_count)
    );

    mul2_seq_ctrl #(.W(2), .CW(16)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .product   (product2),
        .busy      (busy2),
        .op_count  (op_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the W=8 product port
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL sb8_unexpected: got product 0x%0h with nothing expected", product);
                end else begin
                    chk("sb8_product", 32'(product), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Monitor for the W=2 product port
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid2 && out_ready2) begin
                if (exp2_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL sb2_unexpected: got product 0x%0h with nothing expected", product2);
                end else begin
                    chk("sb2_product", 32'(product2), 32'(exp2_q.pop_front()));
                end
            end
        end
    end

    // Count edges from acceptance to out_valid, and cycles spent busy
    task automatic wait_done8(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (!out_valid && n < 200) begin
            if (busy) bc++;
            tick();
            n++;
        end
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ev);
        int n;
        int bc;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        exp_q.push_back(ev);
        tick();
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        wait_done8(n, bc);
        chk("latency8", 32'(n), 32'd16);
        chk("busy_cycles8", 32'(bc), 32'd16);
        tick();
    endtask

    task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic [3:0] ev);
        int n;
        in_valid2 = 1'b1;
        a2        = av;
        b2        = bv;
        exp2_q.push_back(ev);
        tick();
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 50) begin
            tick();
            n++;
        end
        chk("latency2", 32'(n), 32'd1);
        tick();
    endtask

    initial begin
        int n;
        int bc;
        int vo;
        n_vec      = 0;
        n_miss     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        a2         = '0;
        b2         = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_in_reset", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("rst_product", 32'(product), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        op8(8'hFF, 8'hFF, 16'hFE01);
        chk("op_count_1", 32'(op_count), 32'd1);
        op8(8'h02, 8'h01, 16'h0002);
        op8(8'h00, 8'hA5, 16'h0000);
        op8(8'h3C, 8'h0B, 16'h0294);
        chk("op_count_4", 32'(op_count), 32'd4);

        // Backpressure with new operands offered while the result is held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'h12;
        b         = 8'h34;
        exp_q.push_back(16'h03A8);
        tick();
        in_valid = 1'b0;
        wait_done8(n, bc);
        chk("latency_bp", 32'(n), 32'd16);
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'h66;
        for (int k = 0; k < 5; k++) begin
            chk("bp_product_hold", 32'(product), 32'h03A8);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        exp_q.push_back(16'h21DE);
        out_ready = 1'b1;
        tick();
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("op_count_5", 32'(op_count), 32'd5);
        tick();
        chk("accept_after_hs", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_done8(n, bc);
        chk("latency_after_bp", 32'(n), 32'd16);
        tick();
        chk("op_count_6", 32'(op_count), 32'd6);

        // Abort an operation part-way through RUN
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_product", 32'(product), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_op_count", 32'(op_count), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        vo = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) vo++;
            tick();
        end
        chk("abort_no_valid", 32'(vo), 32'd0);
        chk("abort_op_count", 32'(op_count), 32'd0);
        op8(8'h0F, 8'h0F, 16'h00E1);
        chk("op_count_after_abort", 32'(op_count), 32'd1);

        // W=2 corner, ops in quick succession
        op2(2'b11, 2'b10, 4'b0110);
        chk("op_count2_1", 32'(op_count2), 32'd1);
        op2(2'b11, 2'b11, 4'b1001);
        chk("op_count2_2", 32'(op_count2), 32'd2);
        op2(2'b01, 2'b10, 4'b0010);
        chk("op_count2_3", 32'(op_count2), 32'd3);
        op2(2'b10, 2'b10, 4'b0100);
        chk("op_count2_4", 32'(op_count2), 32'd4);

        repeat (2) tick();
        chk("sb8_drained", 32'(exp_q.size()), 32'd0);
        chk("sb2_drained", 32'(exp2_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mul2_seq_ctrl.md
Name: mul2_seq_ctrl

Overview:
- Sequencing controller that computes a W x W unsigned product by time-multiplexing one bin_mul_2_2 cell (the team's 2-bit x 2-bit combinational multiplier; ports x1,x0,y1,y0 -> z3..z0).
- Each cycle it steps through one pair of 2-bit operand digits and accumulates the shifted 4-bit partial product.
- Sits between a valid/ready producer and a valid/ready consumer; one multiplication in flight at a time.

Parameters:
- W, 8, operand width in bits. Must be even and >= 2. D = W/2 digits per operand.
- CW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  controller can accept operands
- a  in  W  multiplicand, unsigned
- b  in  W  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2W  a*b, unsigned
- busy  out  1  high in RUN
- op_count  out  CW  number of completed output handshakes, wraps modulo 2^CW

Behaviour:
- Single clock: clk. Reset is asynchronous and active-low on rst_n, with the polarity and synchronicity fixed as stated.
- Reset (async, any state): state=IDLE, digit indices i=j=0, acc=0, product=0, out_valid=0, busy=0, op_count=0.
- in_ready = (state==IDLE). It is combinational from state, so it is 1 while held in reset.
- IDLE:
  - on in_valid at an edge, register a_r=a and b_r=b, set acc=0, i=j=0, go to RUN.
  - otherwise stay.
- RUN, one term per cycle:
  - drive cell with x = a_r[2i+1:2i] and y = b_r[2j+1:2j].
  - acc <= acc + (z << 2(i+j)).
  - j increments. When j==D-1: j<=0 and i increments.
  - On the cycle with i==D-1 and j==D-1: product <= acc + final term, out_valid <= 1, go to DONE.
- Latency: exactly D*D RUN cycles, independent of operand values (no zero skip). out_valid rises D*D edges after the accepting edge (16 for W=8; 1 for W=2).
- DONE:
  - out_valid=1; product held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready at an edge: out_valid<=0, op_count<=op_count+1 (wrapping), go to IDLE.
  - Operands are not accepted in the handshake cycle; next acceptance is at the earliest one edge later.
- Width and overflow:
  - Max term 9<<(2W-4). acc and product are 2W bits and cannot overflow for valid inputs.
  - product holds its last value in IDLE and RUN until overwritten at the next completion.
- Input stability: a/b changing during RUN or DONE has no effect, because they are registered at acceptance.
- busy = (state==RUN).
- Reset mid-operation (RUN or DONE): result is discarded, op_count is not incremented. The next accepted operation is computed correctly from a clean acc.
- Illegal state encodings recover to IDLE.

Test Plan:
- Reset, W=8:
  - hold rst_n=0, then release -> product=0x0000, out_valid=0, busy=0, op_count=0, in_ready=1.
  - asserting rst_n low asynchronously between edges clears outputs immediately.
- Full-scale, W=8: a=0xFF, b=0xFF, in_valid one cycle, out_ready=1 -> busy for exactly 16 cycles, out_valid on the 16th edge after acceptance, product=0xFE01, op_count=1.
- Small and zero operands, W=8:
  - a=0x02, b=0x01 -> 0x0002.
  - a=0x00, b=0xA5 -> 0x0000, still at 16-cycle latency.
  - a=0x3C, b=0x0B -> 0x0294.
- Backpressure, W=8: a=0x12, b=0x34 with out_ready=0 for 5 cycles after out_valid, and in_valid held high with new a/b -> product stays 0x03A8, in_ready=0, new operands ignored. On out_ready=1 the state returns to IDLE. The next op is accepted no earlier than one edge later.
- Reset mid-RUN, W=8: a=0xFF, b=0xFF, then pulse rst_n low after 7 RUN cycles -> out_valid never asserts, op_count stays 0. A following a=0x0F, b=0x0F yields 0x00E1.
- Parameter corner, W=2: a=2'b11, b=2'b10 -> product=4'b0110 one edge after acceptance. Back-to-back ops with out_ready=1: op_count increments once per op.
